// File: rtl/modarith_pkg.sv
// Shared modular-arithmetic helpers and FSM encoding for the inverse unit.
// Helper functions work at MA_MAXW bits, so instantiating units must keep WIDTH <= MA_MAXW.
package modarith_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int MA_MAXW = 64;

  // (x - y) mod m for x, y < m; the extra top bit acts as the borrow flag.
  function automatic logic [MA_MAXW-1:0] mod_sub(input logic [MA_MAXW-1:0] x,
                                                 input logic [MA_MAXW-1:0] y,
                                                 input logic [MA_MAXW-1:0] m);
    logic [MA_MAXW:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[MA_MAXW]) d = d + {1'b0, m};
    return d[MA_MAXW-1:0];
  endfunction

  // x/2 mod m for odd m: an odd x is made even by adding m, carry kept before the shift.
  function automatic logic [MA_MAXW-1:0] half_mod(input logic [MA_MAXW-1:0] x,
                                                  input logic [MA_MAXW-1:0] m);
    logic [MA_MAXW:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
    return s[MA_MAXW:1];
  endfunction

endpackage

// File: rtl/mod_step_alu.sv
// One step of binary extended Euclid: picks the first matching rule and
// returns the next (u, v, x1, x2) or a finished result.
module mod_step_alu
  import modarith_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] u,
  input  logic [WIDTH-1:0] v,
  input  logic [WIDTH-1:0] x1,
  input  logic [WIDTH-1:0] x2,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] u_nx,
  output logic [WIDTH-1:0] v_nx,
  output logic [WIDTH-1:0] x1_nx,
  output logic [WIDTH-1:0] x2_nx,
  output logic [WIDTH-1:0] res,
  output logic             done,
  output logic             err
);

  always_comb begin
    u_nx  = u;
    v_nx  = v;
    x1_nx = x1;
    x2_nx = x2;
    res   = '0;
    done  = 1'b0;
    err   = 1'b0;
    if (u == WIDTH'(1)) begin
      done = 1'b1;
      res  = x1;
    end else if (v == WIDTH'(1)) begin
      done = 1'b1;
      res  = x2;
    end else if (u == '0 || v == '0) begin
      done = 1'b1;
      err  = 1'b1;
    end else if (!u[0]) begin
      u_nx  = u >> 1;
      x1_nx = WIDTH'(half_mod(MA_MAXW'(x1), MA_MAXW'(m)));
    end else if (!v[0]) begin
      v_nx  = v >> 1;
      x2_nx = WIDTH'(half_mod(MA_MAXW'(x2), MA_MAXW'(m)));
    end else if (u >= v) begin
      u_nx  = u - v;
      x1_nx = WIDTH'(mod_sub(MA_MAXW'(x1), MA_MAXW'(x2), MA_MAXW'(m)));
    end else begin
      v_nx  = v - u;
      x2_nx = WIDTH'(mod_sub(MA_MAXW'(x2), MA_MAXW'(x1), MA_MAXW'(m)));
    end
  end

endmodule

// File: rtl/mod_inverse_seq.sv
// Sequential modular inverse: a*x mod m = 1 via binary extended Euclid, one step per clock.
// state   | meaning
// IDLE    | in_ready high, waiting for an operand pair
// RUN     | one Euclid step per cycle, watchdog counting
// DONE    | out_valid high, result held until out_ready
module mod_inverse_seq
  import modarith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] m_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] inv_out,
  output logic             err_out
);

  localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(4 * WIDTH + 4);

  state_t           state;
  logic [WIDTH-1:0] u, v, x1, x2, m_q;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] u_nx, v_nx, x1_nx, x2_nx, step_res;
  logic             step_done, step_err;
  logic             bad_in;

  assign bad_in = (m_in < WIDTH'(2)) || !m_in[0] || (a_in == '0) || (a_in >= m_in);

  mod_step_alu #(.WIDTH(WIDTH)) u_alu (
    .u     (u),
    .v     (v),
    .x1    (x1),
    .x2    (x2),
    .m     (m_q),
    .u_nx  (u_nx),
    .v_nx  (v_nx),
    .x1_nx (x1_nx),
    .x2_nx (x2_nx),
    .res   (step_res),
    .done  (step_done),
    .err   (step_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      inv_out   <= '0;
      err_out   <= 1'b0;
      u         <= '0;
      v         <= '0;
      x1        <= '0;
      x2        <= '0;
      m_q       <= '0;
      count     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            if (bad_in) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              inv_out   <= '0;
              err_out   <= 1'b1;
            end else begin
              state <= ST_RUN;
              u     <= a_in;
              v     <= m_in;
              x1    <= WIDTH'(1);
              x2    <= '0;
              m_q   <= m_in;
              count <= '0;
            end
          end
        end
        ST_RUN: begin
          count <= count + CNT_W'(1);
          if (step_done) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            inv_out   <= step_err ? '0 : step_res;
            err_out   <= step_err;
          end else if (count == WD_LIMIT) begin
            // Unreachable for legal operands; guards against a stuck datapath.
            state     <= ST_DONE;
            out_valid <= 1'b1;
            inv_out   <= '0;
            err_out   <= 1'b1;
          end else begin
            u  <= u_nx;
            v  <= v_nx;
            x1 <= x1_nx;
            x2 <= x2_nx;
          end
        end
        ST_DONE: begin
          if (out_valid && out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_inverse_seq.sv
// Scoreboard bench for mod_inverse_seq: division-based extended Euclid reference,
// directed corner cases, backpressure, mid-run reset and randomized operands.
module tb_mod_inverse_seq;

  localparam int W       = 32;
  localparam int LAT_DIR = 2 * W + 3;
  localparam int LAT_RND = 4 * W + 5;

  typedef struct {
    logic [W-1:0] inv;
    logic         err;
    int           acc;
    int           lat_exact;
    int           lat_max;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] m_in;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] inv_out;
  logic         err_out;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  exp_t  sb[$];
  bit    hold_ready = 1'b0;
  bit    rand_bp = 1'b0;

  bit           seen = 1'b0;
  int           first_cyc;
  logic [W-1:0] held_inv;
  logic         held_err;

  mod_inverse_seq #(.WIDTH(W), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .m_in      (m_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .inv_out   (inv_out),
    .err_out   (err_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    out_ready = hold_ready ? 1'b0 : (rand_bp ? ($urandom_range(0, 3) != 0) : 1'b1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: classic division-based extended Euclid on 64-bit integers.
  function automatic void ref_model(input logic [W-1:0] a, input logic [W-1:0] m,
                                    output logic [W-1:0] inv, output logic err);
    longint r0, r1, s0, s1, q, t;
    inv = '0;
    err = 1'b1;
    if (m < 2 || m[0] == 1'b0 || a == 0 || a >= m) return;
    r0 = longint'(a); r1 = longint'(m); s0 = 1; s1 = 0;
    while (r1 != 0) begin
      q = r0 / r1;
      t = r0 - q * r1; r0 = r1; r1 = t;
      t = s0 - q * s1; s0 = s1; s1 = t;
    end
    if (r0 != 1) return;
    t = s0 % longint'(m);
    if (t < 0) t += longint'(m);
    inv = W'(t);
    err = 1'b0;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] m, input int lat_max);
    exp_t e;
    int   n;
    @(negedge clk);
    a_in = a; m_in = m; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready still %0b, required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ref_model(a, m, e.inv, e.err);
    e.acc     = cyc;
    e.lat_max = lat_max;
    if (m < 2 || m[0] == 1'b0 || a == 0 || a >= m) e.lat_exact = 1;
    else if (a == 1) e.lat_exact = 2;
    else e.lat_exact = -1;
    sb.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Monitor: result hold checks while stalled, compare on each handshake.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (rst) begin
      seen = 1'b0;
    end else if (out_valid === 1'b1) begin
      if (!seen) begin
        seen      = 1'b1;
        first_cyc = cyc;
        held_inv  = inv_out;
        held_err  = err_out;
      end else begin
        chk("hold_inv", 64'(inv_out), 64'(held_inv));
        chk("hold_err", 64'(err_out), 64'(held_err));
        chk("done_in_ready", 64'(in_ready), 64'd0);
      end
      if (out_ready) begin
        seen = 1'b0;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: inv %0h err %0b with empty scoreboard", inv_out, err_out);
        end else begin
          e   = sb.pop_front();
          lat = first_cyc - e.acc + 1;
          chk("inv_out", 64'(inv_out), 64'(e.inv));
          chk("err_out", 64'(err_out), 64'(e.err));
          if (e.lat_exact >= 0) chk("latency", 64'(lat), 64'(e.lat_exact));
          else if (lat > e.lat_max) begin
            checks++; errors++;
            $display("FAIL latency_bound: got %0d cycles, required <= %0d", lat, e.lat_max);
          end else checks++;
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  initial begin
    logic [W-1:0] ra, rm;
    int kind, n;
    rst = 1'b1; in_valid = 1'b0; a_in = '0; m_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_inv", 64'(inv_out), 64'd0);
    chk("rst_err", 64'(err_out), 64'd0);

    issue(32'd3, 32'd11, LAT_DIR);
    issue(32'd10, 32'd17, LAT_DIR);
    issue(32'd6, 32'd9, LAT_RND);
    issue(32'd0, 32'd7, LAT_RND);
    issue(32'd5, 32'd8, LAT_RND);
    issue(32'd12, 32'd11, LAT_RND);
    issue(32'd0, 32'd1, LAT_RND);
    issue(32'hFFFF_FFFE, 32'hFFFF_FFFF, LAT_RND);
    issue(32'd1, 32'd13, LAT_RND);
    drain();

    hold_ready = 1'b1;
    issue(32'd7, 32'd11, LAT_DIR);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid", 64'(out_valid), 64'd1);
    repeat (10) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid_held", 64'(out_valid), 64'd1);
    end
    hold_ready = 1'b0;
    drain();
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    chk("bp_release_out_valid", 64'(out_valid), 64'd0);
    issue(32'd2, 32'd5, LAT_DIR);
    drain();

    issue(32'd10, 32'd17, LAT_DIR);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_inv", 64'(inv_out), 64'd0);
    issue(32'd3, 32'd11, LAT_DIR);
    drain();

    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      rm = $urandom;
      if (kind < 3) rm = W'($urandom_range(1, 300));
      else if (kind == 3) rm = rm & ~32'd1;
      else rm = rm | 32'd1;
      if (kind == 4) ra = rm + W'($urandom_range(0, 5));
      else ra = (rm == 0) ? W'($urandom) : W'($urandom % rm);
      issue(ra, rm, LAT_RND);
    end
    drain();
    rand_bp = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
